// File: rtl/arb_pkg.sv
// Shared types and helpers for the unified-memory arbiter between
// instruction fetch and load/store.
package arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } grant_t;

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic grant_t pick_grant(input logic   if_req,
                                        input logic   d_req,
                                        input grant_t last);
    if (if_req && d_req) return (last == GNT_IF) ? GNT_D : GNT_IF;
    else if (d_req)      return GNT_D;
    else                 return GNT_IF;
  endfunction

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter modelling the fixed memory latency; done is high
// while the count sits at zero.
module arb_lat_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_cnt <= '0;
    else if (load)          r_cnt <= load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - CNT_W'(1);
  end

  assign done = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store requesters
// with req/ack handshakes, round-robin ties and a fixed access latency.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 2    // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_byte,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

  arb_state_t            r_state;
  grant_t                r_grant;
  grant_t                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_byte;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic                  r_if_ack;
  logic                  r_d_ack;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic   w_any_req;
  logic   w_cnt_load;
  logic   w_cnt_done;
  grant_t w_pick;

  assign w_any_req  = if_req | d_req;
  assign w_pick     = pick_grant(if_req, d_req, r_last_grant);
  assign w_cnt_load = (r_state == IDLE) && w_any_req;

  arb_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (LOAD_VAL),
    .done     (w_cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= GNT_IF;
      r_last_grant <= GNT_D;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byte       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      // NOTE: single-cycle strobes default low here so each is a one-cycle
      // pulse unless a branch below re-asserts it.
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_pick;
            r_state  <= ACCESS;
            r_mem_en <= 1'b1;
            if (w_pick == GNT_IF) begin
              r_addr  <= if_addr;
              r_wdata <= '0;
              r_byte  <= 1'b0;
            end else begin
              r_addr   <= d_addr;
              r_wdata  <= d_wdata;
              r_byte   <= d_byte;
              r_mem_we <= d_we;
            end
          end
        end
        ACCESS: begin
          if (w_cnt_done) begin
            r_mem_en     <= 1'b0;
            r_last_grant <= r_grant;
            r_state      <= RESP;
            if (r_grant == GNT_IF) begin
              r_if_rdata <= mem_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              r_d_rdata <= mem_rdata;
              r_d_ack   <= 1'b1;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_byte  = r_byte;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign stall     = (if_req & ~r_if_ack) | (d_req & ~r_d_ack);

endmodule
